fpu_dispatch: RTL and testbench

Command front-end for the `FPU` block. Accepts floating-point operation commands (A, B, Sel, round) on a valid/ready interface and buffers them in a small FIFO. Issues each command to the FPU with a single-cycle `start` pulse and holds the operands stable for the whole operation. Waits a fixed latency, then captures Y/Overflow/Error into a result register offered downstream on a valid/ready interface. It sits directly upstream of `FPU` and owns its start/operand pins.

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fpu_cmd_fifo.sv | 50 +++++
 rtl/fpu_dispatch.sv | 115 +++++++++++
 tb/tb_fpu_dispatch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the FPU command front-end: operation codes, the queued
// command record and the dispatch FSM states.
package fpu_pkg;

  localparam int SEL_W   = 2;
  localparam int ROUND_W = 2;

  localparam logic [SEL_W-1:0] FPU_ADD = 2'b00;
  localparam logic [SEL_W-1:0] FPU_SUB = 2'b01;
  localparam logic [SEL_W-1:0] FPU_MUL = 2'b10;
  localparam logic [SEL_W-1:0] FPU_DIV = 2'b11;

  typedef struct packed {
    logic [31:0]        a;
    logic [31:0]        b;
    logic [SEL_W-1:0]   sel;
    logic [ROUND_W-1:0] round;
  } fpu_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE
  } fpu_state_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO for fpu_dispatch. Full/empty come from the registered count, so
// neither depends combinationally on the push/pop requests.
module fpu_cmd_fifo
  import fpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fpu_cmd_t         wdata,
  input  logic             pop,
  output fpu_cmd_t         rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fpu_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fpu_dispatch.sv
// Front-end for the FPU: queues commands, issues one at a time with a start
// pulse, waits a fixed latency and holds the result until taken downstream.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_a,
  input  logic [31:0]        in_b,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [ROUND_W-1:0] in_round,
  output logic [31:0]        fpu_a,
  output logic [31:0]        fpu_b,
  output logic [SEL_W-1:0]   fpu_sel,
  output logic [ROUND_W-1:0] fpu_round,
  output logic               fpu_start,
  input  logic [31:0]        fpu_y,
  input  logic               fpu_overflow,
  input  logic               fpu_error,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_y,
  output logic               out_overflow,
  output logic               out_error
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(LATENCY + 1);

  fpu_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  fpu_cmd_t         fifo_wdata;
  fpu_cmd_t         fifo_rdata;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_count;

  assign fifo_wdata   = '{a: in_a, b: in_b, sel: in_sel, round: in_round};
  assign in_ready     = !fifo_full;
  assign fifo_pop     = (state == S_IDLE) && !fifo_empty;
  // Occupancy is kept visible for observation; control uses full/empty.
  assign unused_count = ^fifo_count;

  fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (in_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Operands load only on pop and stay put until the next pop, so the FPU
  // inputs are stable for the whole operation and while the result waits.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      fpu_start    <= 1'b0;
      fpu_a        <= '0;
      fpu_b        <= '0;
      fpu_sel      <= '0;
      fpu_round    <= '0;
      out_valid    <= 1'b0;
      out_y        <= '0;
      out_overflow <= 1'b0;
      out_error    <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            fpu_a     <= fifo_rdata.a;
            fpu_b     <= fifo_rdata.b;
            fpu_sel   <= fifo_rdata.sel;
            fpu_round <= fifo_rdata.round;
            fpu_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= WAIT_W'(LATENCY - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_CAPTURE;
          else                wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        S_CAPTURE: begin
          // A reload in the same cycle as a handshake wins over the clear.
          if (!out_valid || out_ready) begin
            out_y        <= fpu_y;
            out_overflow <= fpu_overflow;
            out_error    <= fpu_error;
            out_valid    <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch with a behavioural FPU that drives garbage
// until LATENCY cycles after start.
module tb_fpu_dispatch;
  import fpu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 8;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_sel, in_round;
  logic [31:0] fpu_a, fpu_b, fpu_y;
  logic [1:0]  fpu_sel, fpu_round;
  logic        fpu_start, fpu_overflow, fpu_error;
  logic        out_valid, out_ready, out_overflow, out_error;
  logic [31:0] out_y;

  fpu_dispatch #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .Clock(Clock), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_round(in_round),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel), .fpu_round(fpu_round),
    .fpu_start(fpu_start), .fpu_y(fpu_y),
    .fpu_overflow(fpu_overflow), .fpu_error(fpu_error),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_overflow(out_overflow), .out_error(out_error)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FPU model: operands captured at start, result valid LATENCY cycles later.
  function automatic logic [33:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] sel);
    if (a == 32'h43700000 && b == 32'h42F00000 && sel == FPU_ADD) return {32'h43B40000, 2'b00};
    if (a == 32'h7F010000 && b == 32'h7F010000) return {32'h7F800000, 2'b10};
    if (a == 32'h7F800000 && b == 32'hFF800000) return {32'h7FC00000, 2'b01};
    return {a + b + {30'b0, sel}, 2'b00};
  endfunction

  logic [31:0] m_a = '0, m_b = '0;
  logic [1:0]  m_sel = '0;
  logic [33:0] m_res;
  int          busy = 0;
  logic        hold_bad = 1'b0;
  int          cyc = 0;
  int          starts = 0;

  typedef struct { logic [31:0] y; logic ovf; logic err; int c; } res_t;
  res_t resq[$];

  assign m_res        = fpu_fn(m_a, m_b, m_sel);
  assign fpu_y        = (busy == 0) ? m_res[33:2] : 32'hDEADBEEF;
  assign fpu_overflow = (busy == 0) && m_res[1];
  assign fpu_error    = (busy == 0) && m_res[0];

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (Reset) begin
      busy <= 0;
    end else begin
      if (busy != 0 && (fpu_a != m_a || fpu_b != m_b || fpu_sel != m_sel)) hold_bad <= 1'b1;
      if (fpu_start) begin
        m_a <= fpu_a; m_b <= fpu_b; m_sel <= fpu_sel;
        busy   <= LATENCY;
        starts <= starts + 1;
      end else if (busy != 0) begin
        busy <= busy - 1;
      end
      if (out_valid && out_ready) resq.push_back('{out_y, out_overflow, out_error, cyc});
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] s, input logic [1:0] r);
    in_valid = v; in_a = a; in_b = b; in_sel = s; in_round = r;
  endtask

  task automatic wait_results(input string tag, input int n, input int budget);
    int k = 0;
    while (resq.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(resq.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [1:0]  sels  [4];
  logic [31:0] exp_b [6];
  int t, c0, r0, s0, first_low, i, k;

  initial begin
    sels  = '{FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV};
    exp_b = '{32'h1010, 32'h1012, 32'h1014, 32'h1016, 32'h1014, 32'h1016};
    Reset = 1'b1; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    step(); step();

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fpu_start", 32'(fpu_start), 32'd0);
    check("rst_fpu_a", fpu_a, 32'd0);
    check("rst_fpu_b", fpu_b, 32'd0);
    check("rst_fpu_sel_round", 32'({fpu_sel, fpu_round}), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", out_y, 32'd0);
    check("rst_out_flags", 32'({out_overflow, out_error}), 32'd0);
    Reset = 1'b0;
    step();

    // Single add: start at t+2, result valid at t+12.
    t = cyc;
    drive(1'b1, 32'h43700000, 32'h42F00000, FPU_ADD, 2'b10);
    step();
    drive(1'b0, '0, '0, '0, '0);
    for (int n = 1; n <= 14; n++) begin
      check("t1_start", 32'(fpu_start), 32'(n == 2));
      if (n == 2) begin
        check("t1_fpu_a", fpu_a, 32'h43700000);
        check("t1_fpu_round", 32'(fpu_round), 32'd2);
      end
      check("t1_out_valid", 32'(out_valid), 32'(n >= 12));
      if (n == 12) check("t1_out_y", out_y, 32'h43B40000);
      step();
    end
    out_ready = 1'b1;
    step();
    check("t1_out_cleared", 32'(out_valid), 32'd0);

    // Burst of six with out_ready high.
    r0 = resq.size(); s0 = starts; first_low = -1; i = 0; k = 0; c0 = cyc;
    while (i < 6 && k < 60) begin
      drive(1'b1, 32'h1000 + 32'(i), 32'h10, sels[i % 4], 2'(i));
      if (in_ready) i++;
      else if (first_low < 0) begin
        first_low = cyc - c0;
        check("t2_count_full", 32'(dut.fifo_count), 32'd4);
      end
      step();
      k++;
    end
    drive(1'b0, '0, '0, '0, '0);
    check("t2_in_ready_low_at", 32'(first_low), 32'd5);
    wait_results("t2_results", r0 + 6, 120);
    if (resq.size() >= r0 + 6) begin
      check("t2_first_cycle", 32'(resq[r0].c - c0), 32'd12);
      for (int j = 0; j < 6; j++) begin
        check("t2_y", resq[r0 + j].y, exp_b[j]);
        if (j > 0) check("t2_spacing", 32'(resq[r0 + j].c - resq[r0 + j - 1].c), 32'd11);
      end
    end
    check("t2_starts", 32'(starts - s0), 32'd6);

    // Backpressure with two queued.
    out_ready = 1'b0; r0 = resq.size(); s0 = starts; c0 = cyc;
    drive(1'b1, 32'h2000, 32'h1, FPU_ADD, 2'b00);
    step();
    drive(1'b1, 32'h3000, 32'h2, FPU_SUB, 2'b00);
    step();
    drive(1'b0, '0, '0, '0, '0);
    while (cyc < c0 + 30) step();
    check("t3_held_valid", 32'(out_valid), 32'd1);
    check("t3_held_y", out_y, 32'h2001);
    check("t3_state_capture", 32'(dut.state), 32'(S_CAPTURE));
    check("t3_starts", 32'(starts - s0), 32'd2);
    out_ready = 1'b1;
    step();
    check("t3_second_valid", 32'(out_valid), 32'd1);
    check("t3_second_y", out_y, 32'h3003);
    step();
    check("t3_drained", 32'(out_valid), 32'd0);
    if (resq.size() >= r0 + 2) begin
      check("t3_order0", resq[r0].y, 32'h2001);
      check("t3_order1", resq[r0 + 1].y, 32'h3003);
      check("t3_b2b", 32'(resq[r0 + 1].c - resq[r0].c), 32'd1);
    end else check("t3_results", 32'(resq.size()), 32'(r0 + 2));

    // Flags.
    r0 = resq.size();
    drive(1'b1, 32'h7F010000, 32'h7F010000, FPU_ADD, 2'b00);
    step();
    drive(1'b0, '0, '0, '0, '0);
    wait_results("t4_ovf_result", r0 + 1, 30);
    if (resq.size() >= r0 + 1) begin
      check("t4_ovf_y", resq[r0].y, 32'h7F800000);
      check("t4_ovf_flag", 32'(resq[r0].ovf), 32'd1);
      check("t4_ovf_err", 32'(resq[r0].err), 32'd0);
    end
    r0 = resq.size();
    drive(1'b1, 32'h7F800000, 32'hFF800000, FPU_ADD, 2'b00);
    step();
    drive(1'b0, '0, '0, '0, '0);
    wait_results("t4_err_result", r0 + 1, 30);
    if (resq.size() >= r0 + 1) begin
      check("t4_err_flag", 32'(resq[r0].err), 32'd1);
      check("t4_err_ovf", 32'(resq[r0].ovf), 32'd0);
    end

    // Reset in WAIT with three queued and a result pending.
    out_ready = 1'b0;
    drive(1'b1, 32'h4000, 32'h0, FPU_ADD, 2'b00);
    step();
    drive(1'b0, '0, '0, '0, '0);
    k = 0;
    while (!out_valid && k < 30) begin step(); k++; end
    check("t5_pending", 32'(out_valid), 32'd1);
    c0 = cyc;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 32'h4100 + 32'(j), 32'h0, FPU_ADD, 2'b00);
      step();
    end
    drive(1'b0, '0, '0, '0, '0);
    check("t5_state_wait", 32'(dut.state), 32'(S_WAIT));
    check("t5_count3", 32'(dut.fifo_count), 32'd3);
    Reset = 1'b1;
    step();
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_fifo_empty", 32'(dut.fifo_count), 32'd0);
    check("t5_fpu_a", fpu_a, 32'd0);
    Reset = 1'b0; s0 = starts; r0 = resq.size(); out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      check("t5_no_start", 32'(fpu_start), 32'd0);
    end
    for (int j = 0; j < 15; j++) step();
    check("t5_no_starts", 32'(starts - s0), 32'd0);
    check("t5_no_stale", 32'(resq.size() - r0), 32'd0);
    check("t5_still_idle", 32'(out_valid), 32'd0);

    // Push and pop together at count 3, across pointer wrap.
    r0 = resq.size(); c0 = cyc;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 32'h5000 + 32'(j), 32'h0, FPU_ADD, 2'b00);
      step();
    end
    drive(1'b0, '0, '0, '0, '0);
    while (cyc < c0 + 12) step();
    check("t6_state_idle", 32'(dut.state), 32'(S_IDLE));
    check("t6_count_before", 32'(dut.fifo_count), 32'd3);
    check("t6_ready_before", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h5004, 32'h0, FPU_ADD, 2'b00);
    step();
    drive(1'b0, '0, '0, '0, '0);
    check("t6_count_after", 32'(dut.fifo_count), 32'd3);
    check("t6_ready_after", 32'(in_ready), 32'd1);
    wait_results("t6_results", r0 + 5, 100);
    if (resq.size() >= r0 + 5)
      for (int j = 0; j < 5; j++) check("t6_order", resq[r0 + j].y, 32'h5000 + 32'(j));

    check("operand_hold", 32'(hold_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
